// File: rtl/rgb_ycbcr_pkg.sv
// rtl/rgb_ycbcr_pkg.sv - BT.601 Q8 coefficients and mode encodings for the RGB to YCbCr pipe
package rgb_ycbcr_pkg;

    localparam logic MODE_FULL   = 1'b0;
    localparam logic MODE_STUDIO = 1'b1;

    localparam int ROUND_Q8 = 128;

    localparam int FULL_Y_R  = 77;
    localparam int FULL_Y_G  = 150;
    localparam int FULL_Y_B  = 29;
    localparam int FULL_CB_R = -43;
    localparam int FULL_CB_G = -85;
    localparam int FULL_CB_B = 128;
    localparam int FULL_CR_R = 128;
    localparam int FULL_CR_G = -107;
    localparam int FULL_CR_B = -21;

    localparam int STU_Y_R  = 66;
    localparam int STU_Y_G  = 129;
    localparam int STU_Y_B  = 25;
    localparam int STU_CB_R = -38;
    localparam int STU_CB_G = -74;
    localparam int STU_CB_B = 112;
    localparam int STU_CR_R = 112;
    localparam int STU_CR_G = -94;
    localparam int STU_CR_B = -18;

    // idx = 3*component + channel, component order Y/Cb/Cr, channel order R/G/B
    function automatic int coef(input logic mode, input int idx);
        case (idx)
            0:       return (mode == MODE_STUDIO) ? STU_Y_R  : FULL_Y_R;
            1:       return (mode == MODE_STUDIO) ? STU_Y_G  : FULL_Y_G;
            2:       return (mode == MODE_STUDIO) ? STU_Y_B  : FULL_Y_B;
            3:       return (mode == MODE_STUDIO) ? STU_CB_R : FULL_CB_R;
            4:       return (mode == MODE_STUDIO) ? STU_CB_G : FULL_CB_G;
            5:       return (mode == MODE_STUDIO) ? STU_CB_B : FULL_CB_B;
            6:       return (mode == MODE_STUDIO) ? STU_CR_R : FULL_CR_R;
            7:       return (mode == MODE_STUDIO) ? STU_CR_G : FULL_CR_G;
            default: return (mode == MODE_STUDIO) ? STU_CR_B : FULL_CR_B;
        endcase
    endfunction

endpackage

// File: rtl/rgb_ycbcr_pipe_if.sv
// rtl/rgb_ycbcr_pipe_if.sv - pixel in/out handshake bundle for the RGB to YCbCr pipe
interface rgb_ycbcr_pipe_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] red_ch;
    logic [DATA_W-1:0] green_ch;
    logic [DATA_W-1:0] blue_ch;
    logic              mode;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] luma_ch;
    logic [DATA_W-1:0] cb_ch;
    logic [DATA_W-1:0] cr_ch;
    logic              skin;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output red_ch, green_ch, blue_ch, mode, in_last, in_valid, out_ready,
        input  in_ready, luma_ch, cb_ch, cr_ch, skin, out_last, out_valid
    );

    modport slave (
        input  red_ch, green_ch, blue_ch, mode, in_last, in_valid, out_ready,
        output in_ready, luma_ch, cb_ch, cr_ch, skin, out_last, out_valid
    );
endinterface

// File: rtl/rgb_ycbcr_sat.sv
// rtl/rgb_ycbcr_sat.sv - clamp a signed value into the unsigned DATA_W range
module rgb_ycbcr_sat #(
    parameter int IN_W   = 20,
    parameter int DATA_W = 8
) (
    input  logic signed [IN_W-1:0] val,
    output logic [DATA_W-1:0]      sat
);
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((1 << DATA_W) - 1);

    always_comb begin
        sat = val[DATA_W-1:0];
        if (val[IN_W-1]) begin
            sat = '0;
        end else if (val > MAX_V) begin
            sat = '1;
        end
    end
endmodule

// File: rtl/rgb_ycbcr_pipe.sv
// rtl/rgb_ycbcr_pipe.sv - 3-stage BT.601 RGB to YCbCr converter with skin-tone flag
module rgb_ycbcr_pipe
    import rgb_ycbcr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CB_MIN = 77,
    parameter int CB_MAX = 127,
    parameter int CR_MIN = 133,
    parameter int CR_MAX = 173
) (
    input  logic           clk,
    input  logic           rst,
    rgb_ycbcr_pipe_if.slave bus
);
    localparam int PW = DATA_W + 10;
    localparam int SW = DATA_W + 12;
    localparam int K  = 1 << (DATA_W - 8);
    localparam logic signed [SW-1:0] OFS_C = SW'(1 << (DATA_W - 1));
    localparam logic signed [SW-1:0] OFS_Y = SW'(16 * K);
    localparam logic [DATA_W-1:0] CB_LO = DATA_W'(CB_MIN * K);
    localparam logic [DATA_W-1:0] CB_HI = DATA_W'(CB_MAX * K);
    localparam logic [DATA_W-1:0] CR_LO = DATA_W'(CR_MIN * K);
    localparam logic [DATA_W-1:0] CR_HI = DATA_W'(CR_MAX * K);

    logic advance;
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    logic signed [PW-1:0] chan [3];
    logic signed [PW-1:0] prod_d [9];
    logic signed [PW-1:0] s1_prod [9];
    logic                 s1_valid, s1_last, s1_mode;

    always_comb begin
        chan[0] = PW'(bus.red_ch);
        chan[1] = PW'(bus.green_ch);
        chan[2] = PW'(bus.blue_ch);
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = PW'(coef(bus.mode, i)) * chan[i % 3];
        end
    end

    logic signed [SW-1:0] s2_sum [3];
    logic                 s2_valid, s2_last, s2_mode;

    // Stage 3 combinational path: floor shift, offsets, clamp, skin window
    logic signed [SW-1:0] pre [3];
    logic [DATA_W-1:0]    sat_y, sat_cb, sat_cr;
    logic                 skin_d;

    always_comb begin
        pre[0] = (s2_sum[0] >>> 8) + ((s2_mode == MODE_STUDIO) ? OFS_Y : '0);
        pre[1] = (s2_sum[1] >>> 8) + OFS_C;
        pre[2] = (s2_sum[2] >>> 8) + OFS_C;
    end

    rgb_ycbcr_sat #(.IN_W(SW), .DATA_W(DATA_W)) u_sat_y  (.val(pre[0]), .sat(sat_y));
    rgb_ycbcr_sat #(.IN_W(SW), .DATA_W(DATA_W)) u_sat_cb (.val(pre[1]), .sat(sat_cb));
    rgb_ycbcr_sat #(.IN_W(SW), .DATA_W(DATA_W)) u_sat_cr (.val(pre[2]), .sat(sat_cr));

    assign skin_d = (sat_cb >= CB_LO) && (sat_cb <= CB_HI) &&
                    (sat_cr >= CR_LO) && (sat_cr <= CR_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.luma_ch   <= '0;
            bus.cb_ch     <= '0;
            bus.cr_ch     <= '0;
            bus.skin      <= 1'b0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            s1_last  <= bus.in_last;
            s1_mode  <= bus.mode;
            for (int i = 0; i < 9; i++) begin
                s1_prod[i] <= prod_d[i];
            end
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_mode  <= s1_mode;
            for (int j = 0; j < 3; j++) begin
                s2_sum[j] <= SW'(s1_prod[3*j]) + SW'(s1_prod[3*j+1]) +
                             SW'(s1_prod[3*j+2]) + SW'(ROUND_Q8);
            end
            bus.out_valid <= s2_valid;
            bus.out_last  <= s2_last;
            bus.luma_ch   <= sat_y;
            bus.cb_ch     <= sat_cb;
            bus.cr_ch     <= sat_cr;
            bus.skin      <= skin_d;
        end
    end
endmodule

// File: tb/tb_rgb_ycbcr_pipe.sv
// tb/tb_rgb_ycbcr_pipe.sv - directed self-checking bench for rgb_ycbcr_pipe
module tb_rgb_ycbcr_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rgb_ycbcr_pipe_if #(.DATA_W(8))  p8 ();
    rgb_ycbcr_pipe_if #(.DATA_W(10)) p10 ();

    rgb_ycbcr_pipe #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(p8));
    rgb_ycbcr_pipe #(.DATA_W(10)) dut10 (.clk(clk), .rst(rst), .bus(p10));

    int checks = 0;
    int errors = 0;

    task automatic idle_inputs();
        p8.red_ch = '0;  p8.green_ch = '0;  p8.blue_ch = '0;
        p8.mode = 1'b0;  p8.in_last = 1'b0; p8.in_valid = 1'b0; p8.out_ready = 1'b1;
        p10.red_ch = '0; p10.green_ch = '0; p10.blue_ch = '0;
        p10.mode = 1'b0; p10.in_last = 1'b0; p10.in_valid = 1'b0; p10.out_ready = 1'b1;
    endtask

    // Drives one pixel into the 8-bit pipe and waits (bounded) for its result.
    task automatic run8(input logic [7:0] r, g, b, input logic m,
                        output logic [7:0] y, cb, cr, output logic sk, output int lat);
        p8.red_ch = r; p8.green_ch = g; p8.blue_ch = b; p8.mode = m;
        p8.in_last = 1'b0; p8.in_valid = 1'b1; p8.out_ready = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        p8.in_valid = 1'b0;
        while (!p8.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        y = p8.luma_ch; cb = p8.cb_ch; cr = p8.cr_ch; sk = p8.skin;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        p8.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (p8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", p8.out_valid); end
        checks++; if (p8.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", p8.out_last); end
        checks++; if ({p8.luma_ch, p8.cb_ch, p8.cr_ch} !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 0", {p8.luma_ch, p8.cb_ch, p8.cr_ch}); end
        checks++; if (p8.skin !== 1'b0) begin errors++; $display("FAIL reset_skin got %b want 0", p8.skin); end
        checks++; if (p8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", p8.in_ready); end
        rst = 1'b0;
        p8.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (p8.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", p8.in_ready); end
    endtask

    task automatic test_vectors();
        logic [7:0] vr  [6] = '{111, 200,   0, 255,   0, 255};
        logic [7:0] vg  [6] = '{  3, 150,   0, 255,   0, 255};
        logic [7:0] vb  [6] = '{122, 120, 255, 255,   0, 255};
        logic       vm  [6] = '{  0,   0,   0,   0,   1,   1};
        logic [7:0] ey  [6] = '{ 49, 162,  29, 255,  16, 235};
        logic [7:0] ecb [6] = '{169, 105, 255, 128, 128, 128};
        logic [7:0] ecr [6] = '{172, 155, 107, 128, 128, 128};
        logic       esk [6] = '{  0,   1,   0,   0,   0,   0};
        logic [7:0] y, cb, cr;
        logic       sk;
        int         lat;
        for (int i = 0; i < 6; i++) begin
            run8(vr[i], vg[i], vb[i], vm[i], y, cb, cr, sk, lat);
            checks++; if (lat !== 3) begin errors++; $display("FAIL vec%0d_latency got %0d want 3", i, lat); end
            checks++; if (y !== ey[i]) begin errors++; $display("FAIL vec%0d_y got %0d want %0d", i, y, ey[i]); end
            checks++; if (cb !== ecb[i]) begin errors++; $display("FAIL vec%0d_cb got %0d want %0d", i, cb, ecb[i]); end
            checks++; if (cr !== ecr[i]) begin errors++; $display("FAIL vec%0d_cr got %0d want %0d", i, cr, ecr[i]); end
            checks++; if (sk !== esk[i]) begin errors++; $display("FAIL vec%0d_skin got %b want %b", i, sk, esk[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  vr  [6] = '{111, 200,   0, 255,   0,  10};
        logic [7:0]  vg  [6] = '{  3, 150,   0, 255,   0,  20};
        logic [7:0]  vb  [6] = '{122, 120, 255, 255,   0,  30};
        logic        vm  [6] = '{  0,   0,   0,   0,   1,   0};
        logic        vl  [6] = '{  0,   0,   1,   0,   0,   1};
        logic [7:0]  ey  [6] = '{ 49, 162,  29, 255,  16,  18};
        logic [7:0]  ecb [6] = '{169, 105, 255, 128, 128, 135};
        logic [7:0]  ecr [6] = '{172, 155, 107, 128, 128, 122};
        logic        esk [6] = '{  0,   1,   0,   0,   0,   0};
        logic [26:0] snap, cur;
        logic        prev_stall, stall;
        int          c, sent, rcv, extra;
        c = 0; sent = 0; rcv = 0; prev_stall = 1'b0; snap = '0;
        while (rcv < 6 && c < 60) begin
            p8.out_ready = !(c >= 4 && c <= 7);
            #1;
            cur = {p8.luma_ch, p8.cb_ch, p8.cr_ch, p8.skin, p8.out_last, p8.out_valid};
            if (prev_stall) begin
                checks++; if (cur !== snap) begin errors++; $display("FAIL bp_hold_c%0d got %h want %h", c, cur, snap); end
            end
            stall = p8.out_valid && !p8.out_ready;
            if (stall) begin
                checks++; if (p8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d got %b want 0", c, p8.in_ready); end
            end
            if (p8.out_valid && p8.out_ready) begin
                checks++;
                if ({p8.luma_ch, p8.cb_ch, p8.cr_ch, p8.skin, p8.out_last} !==
                    {ey[rcv], ecb[rcv], ecr[rcv], esk[rcv], vl[rcv]}) begin
                    errors++;
                    $display("FAIL bp_pix%0d got y%0d cb%0d cr%0d sk%b l%b want y%0d cb%0d cr%0d sk%b l%b", rcv,
                             p8.luma_ch, p8.cb_ch, p8.cr_ch, p8.skin, p8.out_last,
                             ey[rcv], ecb[rcv], ecr[rcv], esk[rcv], vl[rcv]);
                end
                rcv++;
            end
            snap = cur; prev_stall = stall;
            if (sent < 6) begin
                p8.red_ch = vr[sent]; p8.green_ch = vg[sent]; p8.blue_ch = vb[sent];
                p8.mode = vm[sent]; p8.in_last = vl[sent]; p8.in_valid = 1'b1;
                if (p8.in_ready) sent++;
            end else begin
                p8.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        p8.in_valid = 1'b0;
        p8.out_ready = 1'b1;
        checks++; if (rcv !== 6) begin errors++; $display("FAIL bp_count got %0d want 6", rcv); end
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (p8.out_valid) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL bp_duplicate got %0d want 0", extra); end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] y, cb, cr;
        logic       sk;
        int         lat, seen;
        p8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p8.red_ch = 8'd111; p8.green_ch = 8'd3; p8.blue_ch = 8'd122;
            p8.mode = 1'b0; p8.in_last = 1'b0; p8.in_valid = 1'b1;
            if (i == 2) rst = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (p8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", p8.out_valid); end
        rst = 1'b0;
        p8.in_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (p8.out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_leak got %0d want 0", seen); end
        run8(8'd200, 8'd150, 8'd120, 1'b0, y, cb, cr, sk, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL midrst_latency got %0d want 3", lat); end
        checks++; if ({y, cb, cr, sk} !== {8'd162, 8'd105, 8'd155, 1'b1}) begin
            errors++; $display("FAIL midrst_pixel got %0d %0d %0d %b want 162 105 155 1", y, cb, cr, sk);
        end
    endtask

    task automatic test_data_w10();
        logic [9:0] vv  [4] = '{1023, 1023,   0,   0};
        logic       vm  [4] = '{   0,    1,   0,   1};
        logic [9:0] ey  [4] = '{1023,  943,   0,  64};
        int         c, sent, rcv;
        c = 0; sent = 0; rcv = 0;
        p10.out_ready = 1'b1;
        while (rcv < 4 && c < 30) begin
            if (p10.out_valid) begin
                checks++;
                if ({p10.luma_ch, p10.cb_ch, p10.cr_ch, p10.skin} !== {ey[rcv], 10'd512, 10'd512, 1'b0}) begin
                    errors++;
                    $display("FAIL w10_pix%0d got %0d %0d %0d %b want %0d 512 512 0", rcv,
                             p10.luma_ch, p10.cb_ch, p10.cr_ch, p10.skin, ey[rcv]);
                end
                rcv++;
            end
            if (sent < 4) begin
                p10.red_ch = vv[sent]; p10.green_ch = vv[sent]; p10.blue_ch = vv[sent];
                p10.mode = vm[sent]; p10.in_valid = 1'b1;
                if (p10.in_ready) sent++;
            end else begin
                p10.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        p10.in_valid = 1'b0;
        checks++; if (rcv !== 4) begin errors++; $display("FAIL w10_count got %0d want 4", rcv); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_midstream();
        test_data_w10();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rgb_ycbcr_pipe.md
RGB_YCBCR_PIPE -- requirements
Module: rgb_ycbcr_pipe

Interface
REQ-001 Parameter DATA_W, default 8: bits per colour channel, legal range 8..12.
REQ-002 Parameters CB_MIN, CB_MAX, CR_MIN, CR_MAX, defaults 77, 127, 133, 173: inclusive skin window, in 8-bit units, scaled by 2^(DATA_W-8).
REQ-003 Port clk, input, 1: single clock; all logic SHALL be rising-edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Ports red_ch, green_ch, blue_ch, input, DATA_W each: pixel components, unsigned.
REQ-006 Port mode, input, 1: 0 selects full-range BT.601; 1 selects studio-range BT.601. Sampled with each accepted pixel.
REQ-007 Port in_last, input, 1: end-of-line marker, passed through with the pixel.
REQ-008 Ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-009 Ports luma_ch, cb_ch, cr_ch, output, DATA_W each: converted components.
REQ-010 Port skin, output, 1: Cb and Cr both inside the skin window.
REQ-011 Ports out_last (output, 1), out_valid (output, 1) and out_ready (input, 1): output handshake.

Function
REQ-012 A transfer SHALL occur on a clock edge where valid and ready are both 1.
REQ-013 The pipeline SHALL have 3 stages: S1 coefficient products, S2 sums, S3 offset/saturate/skin compare. The output registers SHALL be the S3 registers.
REQ-014 Latency without stall SHALL be 3 cycles from input transfer to out_valid. Throughput SHALL be 1 pixel per cycle.
REQ-015 The pipeline SHALL advance when advance = !out_valid || out_ready. in_ready SHALL equal advance (combinational); bubbles SHALL propagate as invalid stages.
REQ-016 When out_valid=1 and out_ready=0, luma_ch, cb_ch, cr_ch, skin, out_last and out_valid SHALL hold stable, and no stage SHALL change.
REQ-017 Full-range equations, Q8, with rounding and O = 2^(DATA_W-1):
- Y = (77R + 150G + 29B + 128) >>> 8
- Cb = O + ((-43R - 85G + 128B + 128) >>> 8)
- Cr = O + ((128R - 107G - 21B + 128) >>> 8)
REQ-018 Studio-range equations, with K = 2^(DATA_W-8):
- Y = 16K + ((66R + 129G + 25B + 128) >>> 8)
- Cb = O + ((-38R - 74G + 112B + 128) >>> 8)
- Cr = O + ((112R - 94G - 18B + 128) >>> 8)
REQ-019 Arithmetic widths and rounding:
- Products SHALL be signed DATA_W+10 bits; sums SHALL be signed DATA_W+12 bits.
- >>> SHALL be an arithmetic shift (floor).
- No intermediate SHALL overflow.
REQ-020 Each result SHALL saturate to [0, 2^DATA_W-1] before output.
REQ-021 skin SHALL be 1 iff CB_MIN*K <= cb_ch <= CB_MAX*K and CR_MIN*K <= cr_ch <= CR_MAX*K, compared on saturated values.
REQ-022 mode and in_last SHALL travel with their pixel. A mode change between consecutive pixels SHALL affect only later pixels, with no flush.

Reset
REQ-023 While rst=1 at a clock edge:
- all stage valid bits, out_valid and out_last SHALL become 0;
- luma_ch, cb_ch, cr_ch and skin SHALL become 0.
REQ-024 Reset mid-stream SHALL discard all in-flight pixels. The first pixel accepted after rst falls SHALL appear after 3 cycles.
REQ-025 in_ready SHALL be 1 during and after reset.

Structure
REQ-026 Package rgb_ycbcr_pkg SHALL hold:
- the full- and studio-range Q8 coefficient constants;
- the rounding constant 128;
- the mode encoding constants MODE_FULL=0 and MODE_STUDIO=1.
REQ-027 Sub-module rgb_ycbcr_sat SHALL hold the signed-to-unsigned DATA_W saturator. It SHALL be instantiated 3 times in S3.

Verification
REQ-028 Full range, DATA_W=8, (111,3,122) -> (Y,Cb,Cr) = (49,169,172), skin=0, out_valid 3 cycles after accept.
REQ-029 Full range (200,150,120) -> (162,105,155), skin=1; full range (0,0,255) -> (29,255 saturated,107), skin=0.
REQ-030 Studio range: (0,0,0) -> (16,128,128); (255,255,255) -> (235,128,128). Full range (255,255,255) -> (255,128,128).
REQ-031 Backpressure:
- Stimulus: a stream of 6 back-to-back pixels; out_ready held 0 for cycles 4-7.
- Response: outputs stable while stalled and in_ready=0.
- Response: all 6 pixels delivered in order with in_last preserved and no duplicate or lost pixel.
REQ-032 Reset with 3 pixels in flight -> out_valid=0 on the next cycle, none of those pixels emitted; the next pixel appears 3 cycles after its accept.
REQ-033 DATA_W=10, full range, (1023,1023,1023) -> (1023,512,512); mode toggled every pixel -> each output matches its own pixel's mode.
